// File: rtl/pc_fetch_unit.sv
// ============================================================================
// pc_fetch_unit : program counter, instruction fetch over req/ack and status
//                 register, sequenced by the PS/NS fields of the control word.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
  parameter int                    PC_WIDTH   = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            PS,
  input  logic                  NS,
  input  logic [PC_WIDTH-1:0]   in_value,
  input  logic                  status_load,
  input  logic [3:0]            status_in,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_data,
  output logic [INST_WIDTH-1:0] instruction,
  output logic                  inst_valid,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [PC_WIDTH-1:0]   pc_plus4,
  output logic [3:0]            status,
  output logic                  fault
);

  localparam logic [PC_WIDTH-1:0] c_pc_step = PC_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [PC_WIDTH-1:0]     r_pc;
  logic [INST_WIDTH-1:0]   r_instruction;
  logic [3:0]              r_status;
  logic                    r_imem_req;
  logic                    r_inst_valid;
  logic                    r_fault;
  logic [PC_WIDTH-1:0]     w_pc_next;

  always_comb begin
    w_pc_next = r_pc;
    unique case (PS)
      2'b00:   w_pc_next = r_pc;
      2'b01:   w_pc_next = r_pc + c_pc_step;
      2'b10:   w_pc_next = in_value;
      default: w_pc_next = r_pc + c_pc_step + (in_value << 2);
    endcase
  end

  // A misaligned PC is caught on the edge that would enter FETCH, so no request ever leaves
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instruction <= '0;
      r_status      <= '0;
      r_imem_req    <= 1'b0;
      r_inst_valid  <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_pc[1:0] != 2'b00) begin
            r_state <= S_HALT;
            r_fault <= 1'b1;
          end else begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_instruction <= imem_data;
            r_imem_req    <= 1'b0;
            r_inst_valid  <= 1'b1;
            r_state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_pc <= w_pc_next;
          if (status_load) begin
            r_status <= status_in;
          end
          if (!NS) begin
            r_inst_valid <= 1'b0;
            if (w_pc_next[1:0] != 2'b00) begin
              r_state <= S_HALT;
              r_fault <= 1'b1;
            end else begin
              r_state    <= S_FETCH;
              r_imem_req <= 1'b1;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instruction = r_instruction;
  assign inst_valid  = r_inst_valid;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + c_pc_step;
  assign status      = r_status;
  assign fault       = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// tb_pc_fetch_unit : directed self-checking bench for pc_fetch_unit.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  localparam int PC_WIDTH   = 64;
  localparam int INST_WIDTH = 32;

  localparam logic [31:0] c_i1 = 32'h8B02_0020;
  localparam logic [31:0] c_i2 = 32'hD280_0041;
  localparam logic [31:0] c_i3 = 32'h9100_0421;
  localparam logic [31:0] c_i4 = 32'hAA02_03E1;

  logic                  clock;
  logic                  reset;
  logic [1:0]            PS;
  logic                  NS;
  logic [PC_WIDTH-1:0]   in_value;
  logic                  status_load;
  logic [3:0]            status_in;
  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_ack;
  logic [INST_WIDTH-1:0] imem_data;
  logic [INST_WIDTH-1:0] instruction;
  logic                  inst_valid;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   pc_plus4;
  logic [3:0]            status;
  logic                  fault;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_unit #(
    .PC_WIDTH   (PC_WIDTH),
    .INST_WIDTH (INST_WIDTH),
    .RESET_PC   (64'h0)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .PS          (PS),
    .NS          (NS),
    .in_value    (in_value),
    .status_load (status_load),
    .status_in   (status_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instruction (instruction),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .status      (status),
    .fault       (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; PS = 2'b00; NS = 1'b0; in_value = '0;
    status_load = 1'b0; status_in = 4'h0; imem_ack = 1'b0; imem_data = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_req",   imem_req,    0);
    check("rst_valid", inst_valid,  0);
    check("rst_pc",    pc,          0);
    check("rst_inst",  instruction, 0);
    check("rst_stat",  status,      0);
    check("rst_fault", fault,       0);
    check("rst_pc4",   pc_plus4,    4);

    // First fetch at address 0, zero-wait ack
    reset = 1'b0;
    tick();
    check("f1_req",   imem_req,   1);
    check("f1_addr",  imem_addr,  0);
    check("f1_valid", inst_valid, 0);
    imem_ack = 1'b1; imem_data = c_i1;
    tick();
    check("e1_inst",  instruction, c_i1);
    check("e1_valid", inst_valid,  1);
    check("e1_req",   imem_req,    0);
    imem_ack = 1'b0; imem_data = '0; PS = 2'b01; NS = 1'b0;
    tick();
    check("e1_pc",    pc,         4);
    check("f2_req",   imem_req,   1);
    check("f2_valid", inst_valid, 0);

    // Wait states
    PS = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ws_req",   imem_req,   1);
      check("ws_addr",  imem_addr,  4);
      check("ws_valid", inst_valid, 0);
    end
    imem_ack = 1'b1; imem_data = c_i2;
    tick();
    check("ws_exec", inst_valid,  1);
    check("ws_inst", instruction, c_i2);

    imem_ack = 1'b0; PS = 2'b10; in_value = 64'h10; NS = 1'b0;
    tick();
    check("ld_pc",  pc,       64'h10);
    check("ld_req", imem_req, 1);
    imem_ack = 1'b1; imem_data = c_i3;
    tick();
    check("f3_valid", inst_valid, 1);

    // Relative branch with negative offset, multi-cycle EXEC
    imem_ack = 1'b0; PS = 2'b11; in_value = 64'hFFFF_FFFF_FFFF_FFFE; NS = 1'b1;
    tick();
    check("rel_pc",    pc,         64'hC);
    check("rel_valid", inst_valid, 1);
    PS = 2'b10; in_value = 64'h10;
    tick();
    in_value = 64'h40;
    tick();
    check("load_pc", pc, 64'h40);

    // Hold with NS=1 plus status load
    PS = 2'b00; NS = 1'b1; status_load = 1'b1; status_in = 4'b1010;
    tick();
    check("hold_pc",    pc,          64'h40);
    check("hold_inst",  instruction, c_i3);
    check("hold_valid", inst_valid,  1);
    check("stat_load",  status,      4'b1010);
    status_load = 1'b0; PS = 2'b01; NS = 1'b0;
    tick();
    check("adv_pc",    pc,         64'h44);
    check("adv_req",   imem_req,   1);
    check("adv_valid", inst_valid, 0);
    status_load = 1'b1; status_in = 4'b0101;
    tick();
    check("stat_ign", status,   4'b1010);
    check("stat_req", imem_req, 1);
    status_load = 1'b0; imem_ack = 1'b1; imem_data = c_i4;
    tick();
    check("f4_inst", instruction, c_i4);
    imem_ack = 1'b0;

    // PC wrap-around
    PS = 2'b10; in_value = 64'hFFFF_FFFF_FFFF_FFFC; NS = 1'b1;
    tick();
    check("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    PS = 2'b01;
    tick();
    check("wrap_pc",  pc,       0);
    check("wrap_pc4", pc_plus4, 4);

    // Misaligned target -> HALT
    PS = 2'b10; in_value = 64'h3; NS = 1'b0;
    tick();
    check("halt_fault", fault,      1);
    check("halt_req",   imem_req,   0);
    check("halt_valid", inst_valid, 0);
    check("halt_pc",    pc,         3);
    PS = 2'b01; imem_ack = 1'b1; imem_data = c_i1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_halt_req", imem_req,    0);
      check("hold_halt_flt", fault,       1);
      check("hold_halt_pc",  pc,          3);
      check("hold_halt_ins", instruction, c_i4);
    end

    // Asynchronous reset out of HALT
    imem_ack = 1'b0;
    reset = 1'b1;
    #1;
    check("arst_fault", fault, 0);
    check("arst_pc",    pc,    0);
    tick();
    reset = 1'b0;
    tick();
    imem_ack = 1'b1; imem_data = c_i2;
    tick();
    imem_ack = 1'b0; PS = 2'b10; in_value = 64'h100; NS = 1'b0;
    tick();
    tick();
    check("wsr_req",  imem_req,  1);
    check("wsr_addr", imem_addr, 64'h100);

    // Reset mid wait-state; late ack must be ignored
    #2;
    reset = 1'b1; imem_ack = 1'b1; imem_data = c_i3;
    #1;
    check("mid_pc",    pc,         0);
    check("mid_req",   imem_req,   0);
    check("mid_valid", inst_valid, 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_req",   imem_req,    1);
    check("post_inst",  instruction, 0);
    check("post_valid", inst_valid,  0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
